// File: rtl/tetris_cmd_decoder_if.sv
// Command-stream and engine handshake bundle for the tetris command decoder.
// The master side is the command source plus the engine; the decoder is the slave.
interface tetris_cmd_decoder_if;
  logic [7:0] cmd;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       mv_req;
  logic [2:0] mv_op;
  logic       mv_ack;
  logic       mv_ok;

  modport master (
    output cmd, cmd_valid, mv_ack, mv_ok,
    input  cmd_ready, mv_req, mv_op
  );

  modport slave (
    input  cmd, cmd_valid, mv_ack, mv_ok,
    output cmd_ready, mv_req, mv_op
  );
endinterface

// File: rtl/tetris_cmd_decoder.sv
// Validates and decodes tetris command bytes, queues legal moves and issues them
// to the piece engine one at a time with pacing, ack timeout, pause and hard-drop flush.
module tetris_cmd_decoder #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned MIN_GAP     = 2,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  tetris_cmd_decoder_if.slave  bus,
  output logic                 paused,
  output logic                 busy,
  output logic [7:0]           illegal_cnt,
  output logic [7:0]           reject_cnt,
  output logic [7:0]           timeout_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned GW = $clog2(MIN_GAP + 1) + 1;
  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1) + 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((MIN_GAP > 0) ? MIN_GAP - 1 : 0);
  localparam logic [TW-1:0] TMO_LAST = TW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
  localparam logic [2:0] OP_NOP       = 3'd0;
  localparam logic [2:0] OP_HARD_DROP = 3'd6;
  localparam logic [2:0] OP_PAUSE     = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP} state_e;

  state_e          state_q;
  logic [2:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            mv_req_q;
  logic [2:0]      mv_op_q;
  logic            paused_q;
  logic [7:0]      illegal_cnt_q, reject_cnt_q, timeout_cnt_q;
  logic [GW-1:0]   gap_q;
  logic [TW-1:0]   tmo_q;

  logic            cmd_ready;
  logic            accept, legal, push, toggle, illegal, pop, ack, tmo, flush;
  logic [2:0]      cmd_op;

  assign cmd_ready     = (count_q != CW'(DEPTH));
  assign bus.cmd_ready = cmd_ready;
  assign bus.mv_req    = mv_req_q;
  assign bus.mv_op     = mv_op_q;
  assign paused        = paused_q;
  assign busy          = (count_q != '0) || (state_q != S_IDLE);
  assign illegal_cnt   = illegal_cnt_q;
  assign reject_cnt    = reject_cnt_q;
  assign timeout_cnt   = timeout_cnt_q;

  always_comb begin
    cmd_op  = bus.cmd[2:0];
    accept  = bus.cmd_valid & cmd_ready;
    legal   = (bus.cmd[7:3] == '0);
    push    = accept & legal & (cmd_op != OP_NOP) & (cmd_op != OP_PAUSE);
    toggle  = accept & legal & (cmd_op == OP_PAUSE);
    illegal = accept & ~legal;
    pop     = (state_q == S_IDLE) && (count_q != '0) && !paused_q;
    ack     = (state_q == S_REQ) && bus.mv_ack;
    tmo     = (state_q == S_REQ) && !bus.mv_ack && (ACK_TIMEOUT != 0) && (tmo_q == TMO_LAST);
    flush   = ack && (mv_op_q == OP_HARD_DROP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      mv_req_q      <= 1'b0;
      mv_op_q       <= '0;
      paused_q      <= 1'b0;
      illegal_cnt_q <= '0;
      reject_cnt_q  <= '0;
      timeout_cnt_q <= '0;
      gap_q         <= '0;
      tmo_q         <= '0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= cmd_op;

      // Flush drops everything older than this edge; a same-edge push survives alone.
      if (flush) begin
        rd_ptr_q <= wr_ptr_q;
        if (push) begin
          wr_ptr_q <= wr_ptr_q + 1'b1;
          count_q  <= CW'(1);
        end else begin
          count_q  <= '0;
        end
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        if (push && !pop)      count_q <= count_q + 1'b1;
        else if (pop && !push) count_q <= count_q - 1'b1;
      end

      if (toggle) paused_q <= ~paused_q;
      if (illegal && illegal_cnt_q != '1) illegal_cnt_q <= illegal_cnt_q + 1'b1;

      case (state_q)
        S_IDLE: begin
          if (pop) begin
            mv_op_q  <= mem_q[rd_ptr_q];
            mv_req_q <= 1'b1;
            tmo_q    <= '0;
            state_q  <= S_REQ;
          end
        end
        S_REQ: begin
          if (ack || tmo) begin
            mv_req_q <= 1'b0;
            gap_q    <= '0;
            if (ack && !bus.mv_ok && reject_cnt_q != '1) reject_cnt_q <= reject_cnt_q + 1'b1;
            if (tmo && timeout_cnt_q != '1) timeout_cnt_q <= timeout_cnt_q + 1'b1;
            if (MIN_GAP == 0) state_q <= S_IDLE;
            else              state_q <= S_GAP;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_GAP: begin
          if (gap_q == GAP_LAST) state_q <= S_IDLE;
          else                   gap_q   <= gap_q + 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/tetris_cmd_decoder.md
Name: tetris_cmd_decoder

Overview:
Consumer end of the 8-bit bot/player command stream for the tetris core. It accepts command bytes under a valid/ready handshake and validates and decodes them. Legal moves are buffered in a small FIFO and issued one at a time to the game engine over a req/ack handshake, with pacing, timeout, pause and flush-on-hard-drop handling. It sits between the command source (bot or keypad encoder) and the piece-control engine.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2.
MIN_GAP, 2, idle cycles enforced after each completed or abandoned move before the next mv_req.
ACK_TIMEOUT, 16, max cycles mv_req stays high without mv_ack; 0 disables the timeout.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
cmd  in  8  command byte.
cmd_valid  in  1  cmd is valid this cycle.
cmd_ready  out  1  decoder can accept; equals !fifo_full, combinational from registered state only.
mv_req  out  1  move request to engine; registered.
mv_op  out  3  op code of the current request; stable while mv_req=1.
mv_ack  in  1  engine completed the request (single-cycle pulse).
mv_ok  in  1  qualifies mv_ack: 1 = move applied, 0 = move rejected (collision).
paused  out  1  pause state.
busy  out  1  1 when FIFO is non-empty or the FSM is not in IDLE.
illegal_cnt  out  8  saturating count of illegal commands.
reject_cnt  out  8  saturating count of acks with mv_ok=0.
timeout_cnt  out  8  saturating count of timed-out requests.

Behaviour:
- Reset, asynchronous: FIFO empty, FSM=IDLE, mv_req=0, mv_op=0, paused=0, all counters=0, gap and timeout counters=0. This makes cmd_ready=1 and busy=0.
- Accept: a handshake occurs when cmd_valid & cmd_ready are high at a rising edge. No handshake occurs when the FIFO is full; the source must hold cmd.
- Decode of an accepted byte:
  - cmd[7:3]!=0 -> illegal; illegal_cnt+1 (saturating at 255), nothing enqueued.
  - Otherwise decode cmd[2:0]:
    - 0 NOP: accepted and discarded.
    - 1 LEFT, 2 RIGHT, 3 ROT_CW, 4 ROT_CCW, 5 SOFT_DROP, 6 HARD_DROP: enqueued as a 3-bit op.
    - 7 PAUSE: toggles paused on the accepting edge; not enqueued.
- FSM states: IDLE, REQ, GAP.
  - IDLE: if FIFO non-empty and paused=0, pop the head; mv_op<=head, mv_req<=1; go to REQ.
  - REQ: mv_req held high. When mv_ack=1 at an edge:
    - mv_req<=0.
    - If mv_ok=0, reject_cnt+1.
    - If mv_op==6, flush the FIFO.
    - Go to GAP (or IDLE if MIN_GAP==0).
  - REQ timeout: if ACK_TIMEOUT>0 and ACK_TIMEOUT cycles pass in REQ without mv_ack, then mv_req<=0, timeout_cnt+1, no flush even for op 6; go to GAP/IDLE.
  - GAP: stay exactly MIN_GAP cycles, then go to IDLE.
  - mv_ack outside REQ is ignored.
- Latency: a byte accepted at edge E into an empty FIFO, with FSM in IDLE and paused=0, gives mv_req=1 after edge E+1. Back-to-back ops have their mv_req rising edges spaced ≥ 1 + MIN_GAP + ack-delay cycles.
- Pause: only blocks new pops. An in-flight REQ completes normally. The FIFO keeps filling while paused. Unpause resumes issuing from IDLE on the next edge.
- Flush on HARD_DROP ack: clears every entry stored before that edge. A push on the same edge is retained as the sole entry, because it belongs to the next piece.
- Simultaneous push and pop on a full FIFO: not possible, since cmd_ready=0 when full. Simultaneous push and pop when non-full: both occur and the count is unchanged.
- Pointers wrap modulo DEPTH. The count register is 0..DEPTH.
- Counters saturate at 8'hFF and never wrap.
- Reset asserted mid-REQ: mv_req drops immediately (asynchronously). All state returns to its reset values.

Test Plan:
1. After reset, send cmd=8'h01. Required: mv_req=1, mv_op=1 after edge E+1. Ack with mv_ok=1 after 3 cycles. Required: mv_req=0, then 2 GAP cycles, then busy=0, reject_cnt=0.
2. Send 8'h09, 8'h00, 8'h07, with engine stalled. Required: illegal_cnt=1, nothing enqueued, paused=1, mv_req stays 0. Then send 8'h02 -> busy=1 while paused. Send 8'h07 -> op 2 issued.
3. Hold mv_ack=0 and push 6 moves. Required: cmd_ready=0 after 5 accepts (1 in flight plus 4 queued). The in-flight request times out at 16 cycles, so timeout_cnt=1. FIFO order of mv_op is preserved.
4. Queue ops 6,1,2,3. Ack op 6 while simultaneously pushing 8'h04. Required: ops 1,2,3 discarded. Next mv_op=4.
5. Ack 300 requests with mv_ok=0. Required: reject_cnt=8'hFF, no wrap.
6. Assert rst while mv_req=1 and the FIFO holds 3 entries. Required: mv_req=0 asynchronously. After release: cmd_ready=1, busy=0, counters 0.
